cla_subtractor_pipe_32bit: RTL and testbench

//  Pipelined 32-bit subtractor: diff = a - b - borrow_in, computed as a + ~b + ~borrow_in
//   by STAGE_W-bit carry-lookahead slices, one slice per pipeline stage, borrow rippled

---
 rtl/cla_subtractor_pipe_32bit_pkg.sv | 22 ++
 rtl/cla_subtractor_pipe_32bit_if.sv | 26 ++
 rtl/cla_subtractor_pipe_32bit_slice.sv | 41 ++++
 rtl/cla_subtractor_pipe_32bit.sv | 90 +++++++++
 tb/tb_cla_subtractor_pipe_32bit.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cla_subtractor_pipe_32bit_pkg.sv
// rtl/cla_subtractor_pipe_32bit_pkg.sv - shared widths, stage record and helpers for the pipelined subtractor
package cla_subtractor_pipe_32bit_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_STAGE_W = 8;

  function automatic int num_stages(input int width, input int stage_w);
    return width / stage_w;
  endfunction

  // diff_lo fills from the bottom one slice per stage; a_hi/nb_hi carry the operands forward
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic                 ovf;
    logic                 zero;
    logic [DEF_WIDTH-1:0] diff_lo;
    logic [DEF_WIDTH-1:0] a_hi;
    logic [DEF_WIDTH-1:0] nb_hi;
  } stage_t;

endpackage

// File: rtl/cla_subtractor_pipe_32bit_if.sv
// rtl/cla_subtractor_pipe_32bit_if.sv - operand/result stream bundle for the pipelined subtractor
interface cla_subtractor_pipe_32bit_if #(
  parameter int WIDTH = 32
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             borrow_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] diff_o;
  logic             borrow_o;
  logic             ovf_o;
  logic             zero_o;

  modport slave (
    input  valid_i, a_i, b_i, borrow_i, ready_i,
    output ready_o, valid_o, diff_o, borrow_o, ovf_o, zero_o
  );

  modport master (
    output valid_i, a_i, b_i, borrow_i, ready_i,
    input  ready_o, valid_o, diff_o, borrow_o, ovf_o, zero_o
  );
endinterface

// File: rtl/cla_subtractor_pipe_32bit_slice.sv
// rtl/cla_subtractor_pipe_32bit_slice.sv - STAGE_W-bit carry-lookahead adder slice
module cla_subtractor_pipe_32bit_slice #(
  parameter int STAGE_W = 8
) (
  input  logic [STAGE_W-1:0] i_a,
  input  logic [STAGE_W-1:0] i_b,
  input  logic               i_cin,
  output logic [STAGE_W-1:0] o_sum,
  output logic               o_cout
);

  logic [STAGE_W-1:0] w_p;
  logic [STAGE_W-1:0] w_g;
  logic [STAGE_W:0]   w_c;
  logic               w_acc;
  logic               w_prod;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Each carry is the flat sum-of-products of G/P terms, not a ripple through w_c
  always_comb begin
    w_c    = '0;
    w_acc  = 1'b0;
    w_prod = 1'b0;
    w_c[0] = i_cin;
    for (int i = 0; i < STAGE_W; i++) begin
      w_acc  = w_g[i];
      w_prod = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_acc  = w_acc | (w_prod & w_g[j]);
        w_prod = w_prod & w_p[j];
      end
      w_c[i+1] = w_acc | (w_prod & i_cin);
    end
  end

  assign o_sum  = w_p ^ w_c[STAGE_W-1:0];
  assign o_cout = w_c[STAGE_W];

endmodule

// File: rtl/cla_subtractor_pipe_32bit.sv
// rtl/cla_subtractor_pipe_32bit.sv - pipelined a - b - borrow as a + ~b + ~borrow, one CLA slice per stage
module cla_subtractor_pipe_32bit
  import cla_subtractor_pipe_32bit_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int STAGE_W = DEF_STAGE_W
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  cla_subtractor_pipe_32bit_if.slave  bus
);

  localparam int NUM_STAGES = num_stages(WIDTH, STAGE_W);
  localparam int LAST       = NUM_STAGES - 1;

  stage_t                r_stage [NUM_STAGES];
  stage_t                w_src   [NUM_STAGES];
  stage_t                w_nxt   [NUM_STAGES];
  logic [STAGE_W-1:0]    w_sum   [NUM_STAGES];
  logic [NUM_STAGES-1:0] w_cout;
  logic [NUM_STAGES-1:0] w_load;
  logic [NUM_STAGES-1:0] w_unused;

  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) w_src[k] = '0;
    w_src[0].valid = bus.valid_i;
    w_src[0].carry = ~bus.borrow_i;
    w_src[0].a_hi  = bus.a_i;
    w_src[0].nb_hi = ~bus.b_i;
    for (int k = 1; k < NUM_STAGES; k++) w_src[k] = r_stage[k-1];
  end

  generate
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
      cla_subtractor_pipe_32bit_slice #(.STAGE_W(STAGE_W)) u_slice (
        .i_a    (w_src[k].a_hi[k*STAGE_W +: STAGE_W]),
        .i_b    (w_src[k].nb_hi[k*STAGE_W +: STAGE_W]),
        .i_cin  (w_src[k].carry),
        .o_sum  (w_sum[k]),
        .o_cout (w_cout[k])
      );
      assign w_unused[k] = ^{r_stage[k].a_hi, r_stage[k].nb_hi, r_stage[k].ovf, r_stage[k].zero};
    end
  endgenerate

  // The last stage stores borrow (inverted carry) so a cleared register reads as borrow_o=0
  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      w_nxt[k] = w_src[k];
      w_nxt[k].diff_lo[k*STAGE_W +: STAGE_W] = w_sum[k];
      w_nxt[k].carry = w_cout[k];
      if (k == LAST) begin
        w_nxt[k].carry = ~w_cout[k];
        w_nxt[k].ovf   = (w_src[k].a_hi[WIDTH-1] ^ ~w_src[k].nb_hi[WIDTH-1]) &
                         (w_src[k].a_hi[WIDTH-1] ^ w_sum[k][STAGE_W-1]);
        w_nxt[k].zero  = (w_nxt[k].diff_lo == '0);
      end
    end
  end

  // A stage advances when empty or when its successor advances, so bubbles collapse
  always_comb begin
    w_load       = '0;
    w_load[LAST] = ~r_stage[LAST].valid | bus.ready_i;
    for (int k = LAST - 1; k >= 0; k--) begin
      w_load[k] = ~r_stage[k].valid | w_load[k+1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_STAGES; k++) r_stage[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (w_load[k]) begin
          if (w_src[k].valid) r_stage[k] <= w_nxt[k];
          else                r_stage[k].valid <= 1'b0;
        end
      end
    end
  end

  assign bus.ready_o  = w_load[0];
  assign bus.valid_o  = r_stage[LAST].valid;
  assign bus.diff_o   = r_stage[LAST].diff_lo[WIDTH-1:0];
  assign bus.borrow_o = r_stage[LAST].carry;
  assign bus.ovf_o    = r_stage[LAST].ovf;
  assign bus.zero_o   = r_stage[LAST].zero;

endmodule

// File: tb/tb_cla_subtractor_pipe_32bit.sv
// tb/tb_cla_subtractor_pipe_32bit.sv - scoreboard bench for the pipelined subtractor
module tb_cla_subtractor_pipe_32bit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cla_subtractor_pipe_32bit_if #(.WIDTH(32)) bus ();

  cla_subtractor_pipe_32bit dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int accept_count = 0;
  int emit_count = 0;
  int first_emit_cycle = 0;
  int last_emit_cycle = 0;
  logic [34:0] sb [$];
  logic [34:0] cur_exp;

  function automatic logic [34:0] pack(input logic br, input logic ov, input logic z, input logic [31:0] d);
    return {br, ov, z, d};
  endfunction

  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b, input logic br);
    logic [32:0] full;
    logic [31:0] d;
    full = {1'b0, a} - {1'b0, b} - {32'd0, br};
    d = full[31:0];
    return pack(full[32], (a[31] ^ b[31]) & (a[31] ^ d[31]), d == 32'd0, d);
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic br, input logic [34:0] e);
    bus.a_i = a;
    bus.b_i = b;
    bus.borrow_i = br;
    bus.valid_i = 1'b1;
    cur_exp = e;
  endtask

  task automatic step();
    logic acc, emt;
    logic [34:0] got, e;
    @(negedge clk);
    acc = bus.valid_i && bus.ready_o;
    emt = bus.valid_o && bus.ready_i;
    if (emt) begin
      got = {bus.borrow_o, bus.ovf_o, bus.zero_o, bus.diff_o};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL emit_unexpected got=%h expected=none", got);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL result got=%h expected=%h", got, e);
        end
      end
      if (emit_count == 0) first_emit_cycle = cycle;
      emit_count++;
      last_emit_cycle = cycle;
    end
    if (acc) begin
      sb.push_back(cur_exp);
      accept_count++;
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
    end
  endtask

  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic br, input logic [34:0] e);
    int n;
    bus.ready_i = 1'b1;
    drive(a, b, br, e);
    step();
    bus.valid_i = 1'b0;
    n = 0;
    while (!bus.valid_o && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL latency got=%0d expected=3", n);
    end
    drain(10);
  endtask

  task automatic test_reset();
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.borrow_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.valid_o, bus.diff_o, bus.borrow_o, bus.ovf_o, bus.zero_o} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h expected=0", {bus.valid_o, bus.diff_o, bus.borrow_o, bus.ovf_o, bus.zero_o});
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release ready_o=%b valid_o=%b expected ready_o=1 valid_o=0", bus.ready_o, bus.valid_o);
    end
  endtask

  task automatic test_single();
    send_one(32'h0000_0005, 32'h0000_0003, 1'b0, pack(1'b0, 1'b0, 1'b0, 32'h0000_0002));
  endtask

  task automatic test_corners();
    logic [31:0] ta [4];
    logic [31:0] tb_ [4];
    logic        tbr [4];
    logic [34:0] te [4];
    ta[0] = 32'h0000_0000; tb_[0] = 32'h0000_0001; tbr[0] = 1'b0; te[0] = pack(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    ta[1] = 32'h8000_0000; tb_[1] = 32'h0000_0001; tbr[1] = 1'b0; te[1] = pack(1'b0, 1'b1, 1'b0, 32'h7FFF_FFFF);
    ta[2] = 32'h0001_0000; tb_[2] = 32'h0000_0001; tbr[2] = 1'b1; te[2] = pack(1'b0, 1'b0, 1'b0, 32'h0000_FFFE);
    ta[3] = 32'h1234_5678; tb_[3] = 32'h1234_5678; tbr[3] = 1'b0; te[3] = pack(1'b0, 1'b0, 1'b1, 32'h0000_0000);
    for (int i = 0; i < 4; i++) send_one(ta[i], tb_[i], tbr[i], te[i]);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    logic br;
    bus.ready_i = 1'b1;
    accept_count = 0;
    emit_count = 0;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      br = 1'($urandom_range(0, 1));
      drive(a, b, br, model(a, b, br));
      step();
    end
    drain(20);
    checks++;
    if (accept_count != 8) begin
      errors++;
      $display("FAIL b2b_accepts got=%0d expected=8", accept_count);
    end
    checks++;
    if (emit_count != 8 || last_emit_cycle - first_emit_cycle != 7) begin
      errors++;
      $display("FAIL b2b_emits got count=%0d span=%0d expected count=8 span=7", emit_count, last_emit_cycle - first_emit_cycle);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    logic [34:0] held;
    bus.ready_i = 1'b0;
    accept_count = 0;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = $urandom;
      drive(a, b, 1'b0, model(a, b, 1'b0));
      step();
    end
    checks++;
    if (accept_count != 4) begin
      errors++;
      $display("FAIL stall_accepts got=%0d expected=4", accept_count);
    end
    checks++;
    if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_flags ready_o=%b valid_o=%b expected ready_o=0 valid_o=1", bus.ready_o, bus.valid_o);
    end
    held = {bus.borrow_o, bus.ovf_o, bus.zero_o, bus.diff_o};
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.borrow_o, bus.ovf_o, bus.zero_o, bus.diff_o} !== held) begin
        errors++;
        $display("FAIL stall_stable got=%h expected=%h", {bus.borrow_o, bus.ovf_o, bus.zero_o, bus.diff_o}, held);
      end
    end
    drain(20);
  endtask

  task automatic test_reset_midflight();
    logic [31:0] a, b;
    bus.ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = $urandom | 32'h1;
      b = $urandom;
      drive(a, b, 1'b0, model(a, b, 1'b0));
      step();
    end
    bus.valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.valid_o, bus.diff_o, bus.borrow_o, bus.ovf_o, bus.zero_o} !== 36'd0) begin
      errors++;
      $display("FAIL async_reset got=%h expected=0", {bus.valid_o, bus.diff_o, bus.borrow_o, bus.ovf_o, bus.zero_o});
    end
    sb.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_one(32'd10, 32'd4, 1'b0, pack(1'b0, 1'b0, 1'b0, 32'd6));
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic br;
    int n;
    accept_count = 0;
    n = 0;
    while (accept_count < 10000 && n < 40000) begin
      a = $urandom;
      b = ($urandom_range(0, 15) == 0) ? a : 32'($urandom);
      br = 1'($urandom_range(0, 1));
      drive(a, b, br, model(a, b, br));
      bus.valid_i = ($urandom_range(0, 3) != 0);
      bus.ready_i = ($urandom_range(0, 3) != 0);
      step();
      n++;
    end
    checks++;
    if (accept_count != 10000) begin
      errors++;
      $display("FAIL random_accepts got=%0d expected=10000", accept_count);
    end
    drain(100);
  endtask

  initial begin
    test_reset();
    test_single();
    test_corners();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
